// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter: sizes, packet field
// bounds, the broadcast destination code and the arbiter state encoding.
package bus_arb_pkg;

    localparam int DRVRS   = 4;
    localparam int PCKG_SZ = 65;

    // Packet layout: [64:62] destination id, [61:60] tag, [59:0] payload
    localparam int ID_HI      = PCKG_SZ - 1;
    localparam int ID_LO      = PCKG_SZ - 3;
    localparam int ID_W       = ID_HI - ID_LO + 1;
    localparam int TAG_HI     = PCKG_SZ - 4;
    localparam int TAG_LO     = PCKG_SZ - 5;
    localparam int PAYLOAD_HI = PCKG_SZ - 6;
    localparam int GRANT_W    = $clog2(DRVRS);

    localparam logic [ID_W-1:0] BROADCAST = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        DELIVER,
        DROP
    } arb_state_e;

    // A destination is deliverable if it names an existing device or is broadcast
    function automatic logic dest_is_valid(input logic [ID_W-1:0] dest, input int n_dev);
        return (dest == BROADCAST) || (int'(dest) < n_dev);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: scans the request vector starting one
// above the last grant and wrapping, returning the first requester found.
module rr_picker #(
    parameter int N = bus_arb_pkg::DRVRS,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] winner_id,
    output logic         valid
);

    // Walk the devices in rotating priority order; the first request seen wins
    always_comb begin : pick
        int idx;
        winner_id = '0;
        valid     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!valid && req[W'(idx)]) begin
                valid     = 1'b1;
                winner_id = W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter moving one packet at a time from per-device source
// FIFOs to per-device destination FIFOs, with broadcast and drop of packets
// addressed to a non-existent device.
module bus_arbiter_rr #(
    parameter int DRVRS   = bus_arb_pkg::DRVRS,
    parameter int PCKG_SZ = bus_arb_pkg::PCKG_SZ
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DRVRS-1:0]                pndng,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
    input  logic [DRVRS-1:0]                full,
    output logic [DRVRS-1:0]                pop,
    output logic [DRVRS-1:0]                push,
    output logic [PCKG_SZ-1:0]              D_push,
    output logic [$clog2(DRVRS)-1:0]        grant_id,
    output logic                            busy,
    output logic                            err_dest
);

    import bus_arb_pkg::*;

    localparam int GW = $clog2(DRVRS);
    localparam logic [DRVRS-1:0] ONE = {{(DRVRS-1){1'b0}}, 1'b1};

    arb_state_e         state_q;
    arb_state_e         state_d;
    logic [GW-1:0]      grant_q;
    logic [GW-1:0]      last_q;
    logic [GW-1:0]      pick_id;
    logic               pick_valid;
    logic [PCKG_SZ-1:0] pkt_q;
    logic [ID_W-1:0]    head_dest;
    logic [ID_W-1:0]    pkt_dest;
    logic [DRVRS-1:0]   src_mask;
    logic [DRVRS-1:0]   dest_mask;
    logic [DRVRS-1:0]   bcast_mask;

    rr_picker #(
        .N (DRVRS),
        .W (GW)
    ) u_picker (
        .req        (pndng),
        .last_grant (last_q),
        .winner_id  (pick_id),
        .valid      (pick_valid)
    );

    assign head_dest  = D_pop[grant_q][ID_HI:ID_LO];
    assign pkt_dest   = pkt_q[ID_HI:ID_LO];
    assign src_mask   = ONE << grant_q;
    assign dest_mask  = ONE << pkt_dest;
    assign bcast_mask = ~src_mask;

    assign D_push   = pkt_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

    // State, grant, last grant and packet registers; reset discards any packet in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(DRVRS - 1);
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_valid) begin
                grant_q <= pick_id;
            end
            if (state_q == POP) begin
                pkt_q  <= D_pop[grant_q];
                last_q <= grant_q;
            end
        end
    end

    // Next-state and strobe decode; pushes wait until every target has room
    always_comb begin
        state_d  = state_q;
        pop      = '0;
        push     = '0;
        err_dest = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = POP;
                end
            end
            POP: begin
                pop     = src_mask;
                state_d = dest_is_valid(head_dest, DRVRS) ? DELIVER : DROP;
            end
            DELIVER: begin
                if (pkt_dest == BROADCAST) begin
                    if ((full & bcast_mask) == '0) begin
                        push    = bcast_mask;
                        state_d = IDLE;
                    end
                end else if ((full & dest_mask) == '0) begin
                    push    = dest_mask;
                    state_d = IDLE;
                end
            end
            DROP: begin
                err_dest = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: source FIFOs are modelled as queues,
// a round-robin reference model predicts every transaction, and a monitor
// compares each pop / push / drop the DUT presents against the prediction.
module tb_bus_arbiter_rr;

    import bus_arb_pkg::*;

    typedef struct {
        int                 src;
        logic [PCKG_SZ-1:0] pkt;
        logic [DRVRS-1:0]   mask;
        bit                 drop;
    } exp_t;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [DRVRS-1:0]              pndng;
    logic [DRVRS-1:0][PCKG_SZ-1:0] D_pop;
    logic [DRVRS-1:0]              full;
    logic [DRVRS-1:0]              pop;
    logic [DRVRS-1:0]              push;
    logic [PCKG_SZ-1:0]            D_push;
    logic [GRANT_W-1:0]            grant_id;
    logic                          busy;
    logic                          err_dest;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [PCKG_SZ-1:0] src_q[DRVRS][$];
    logic [PCKG_SZ-1:0] mq[DRVRS][$];
    exp_t               exp_q[$];
    int                 model_last = DRVRS - 1;
    logic [DRVRS-1:0]   full_force = '0;
    bit                 bp_rand    = 1'b0;
    bit                 lat_en     = 1'b0;
    bit                 spacing_en = 1'b0;

    bus_arbiter_rr #(
        .DRVRS   (DRVRS),
        .PCKG_SZ (PCKG_SZ)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .full     (full),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .grant_id (grant_id),
        .busy     (busy),
        .err_dest (err_dest)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency and spacing checks
    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    task automatic checkOutput(input string name, input logic [PCKG_SZ-1:0] actual,
                               input logic [PCKG_SZ-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Queue a packet in a source FIFO; the model only learns of it if model_sees
    task automatic applyStimulus(input int dev, input logic [2:0] dest, input logic [1:0] tag,
                                 input logic [59:0] payload, input bit model_sees);
        logic [PCKG_SZ-1:0] p;
        p = {dest, tag, payload};
        src_q[dev].push_back(p);
        if (model_sees) begin
            mq[dev].push_back(p);
        end
    endtask

    // Reference model: drain the model queues in round-robin order into the scoreboard
    task automatic run_model();
        exp_t             e;
        int               d;
        bit               found;
        logic [2:0]       dest;
        logic [DRVRS-1:0] one;
        one = 1;
        forever begin
            found = 1'b0;
            d     = 0;
            for (int k = 1; k <= DRVRS; k++) begin
                if (!found && mq[(model_last + k) % DRVRS].size() > 0) begin
                    found = 1'b1;
                    d     = (model_last + k) % DRVRS;
                end
            end
            if (!found) break;
            e.src = d;
            e.pkt = mq[d].pop_front();
            dest  = e.pkt[PCKG_SZ-1 -: 3];
            if (dest == 3'b111) begin
                e.mask = ~(one << d);
                e.drop = 1'b0;
            end else if (int'(dest) < DRVRS) begin
                e.mask = one << dest;
                e.drop = 1'b0;
            end else begin
                e.mask = '0;
                e.drop = 1'b1;
            end
            exp_q.push_back(e);
            model_last = d;
        end
    endtask

    task automatic wait_pop(output logic [DRVRS-1:0] seen);
        seen = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pop != '0) begin
                seen = pop;
                break;
            end
        end
        checkOutput("pop_seen", PCKG_SZ'(seen != '0), 1);
    endtask

    task automatic wait_drain(input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && busy === 1'b0) done = 1'b1;
        end
        checkOutput("drain_pending", exp_q.size(), 0);
        checkOutput("drain_idle", busy, 0);
    endtask

    // Source/destination FIFO model: retire popped heads after the edge, drive pndng/D_pop/full
    initial begin : driver
        logic [DRVRS-1:0] seen;
        pndng = '0;
        D_pop = '0;
        full  = '0;
        forever begin
            @(negedge clk);
            seen = pop;
            @(posedge clk);
            #1;
            for (int i = 0; i < DRVRS; i++) begin
                if (seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                full[i]  = full_force[i] | (bp_rand && ($urandom_range(0, 3) == 0));
                pndng[i] = (src_q[i].size() > 0);
                D_pop[i] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
            end
        end
    end

    // Monitor: every pop, push or drop the DUT shows is matched against the scoreboard head
    initial begin : monitor
        exp_t e;
        int   prev_done;
        int   pop_cycle;
        prev_done = -1;
        pop_cycle = 0;
        forever begin
            @(negedge clk);
            if (!spacing_en) prev_done = -1;
            if (reset === 1'b1) begin
                if (pop != '0) begin
                    if (exp_q.size() == 0) checkOutput("unexpected_pop", pop, 0);
                    else checkOutput("pop_src", pop, PCKG_SZ'(1) << exp_q[0].src);
                    pop_cycle = cycle;
                end
                if (push != '0 || err_dest) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_push", {push, err_dest}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("push_mask", push, e.mask);
                        checkOutput("err_dest", err_dest, e.drop);
                        checkOutput("grant_id", grant_id, e.src);
                        if (!e.drop) checkOutput("d_push", D_push, e.pkt);
                        if (lat_en) checkOutput("pop_to_push", cycle - pop_cycle, 1);
                        if (spacing_en && prev_done >= 0) checkOutput("spacing", cycle - prev_done, 3);
                        prev_done = cycle;
                    end
                end
            end
        end
    end

    initial begin
        logic [DRVRS-1:0]   seen;
        logic [PCKG_SZ-1:0] held;
        int                 n;

        // Reset state
        reset = 1'b0;
        #12;
        checkOutput("rst_pop", pop, 0);
        checkOutput("rst_push", push, 0);
        checkOutput("rst_d_push", D_push, 0);
        checkOutput("rst_grant", grant_id, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err_dest, 0);
        @(negedge clk);
        reset = 1'b1;

        // Fairness: all four devices loaded, order 0,1,2,3,0,... one push every 3 cycles
        lat_en     = 1'b1;
        spacing_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < DRVRS; d++) begin
                applyStimulus(d, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                              60'({$urandom(), $urandom()}), 1'b1);
            end
        end
        run_model();
        wait_drain(200);
        spacing_en = 1'b0;

        // Single packet from device 0 to device 1
        applyStimulus(0, 3'b001, 2'b00, '1, 1'b1);
        run_model();
        wait_drain(50);

        // Back-pressure: destination 1 full for five DELIVER cycles
        lat_en     = 1'b0;
        full_force = 4'b0010;
        applyStimulus(0, 3'b001, 2'b10, 60'h0123_4567_89AB_CDE, 1'b1);
        held = {3'b001, 2'b10, 60'h0123_4567_89AB_CDE};
        run_model();
        wait_pop(seen);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_no_push", push, 0);
            checkOutput("bp_d_push_stable", D_push, held);
        end
        full_force = '0;
        @(negedge clk);
        checkOutput("bp_release_push", push, 4'b0010);
        wait_drain(50);

        // Invalid destination is dropped with one error pulse
        lat_en = 1'b1;
        applyStimulus(0, 3'b101, 2'b01, 60'hABC, 1'b1);
        run_model();
        wait_drain(50);

        // Broadcast from device 2 reaches everyone but the source
        applyStimulus(2, 3'b111, 2'b11, 60'h5A5A, 1'b1);
        run_model();
        wait_drain(50);

        // Device 1 withdraws its request while device 0 is in flight
        applyStimulus(0, 3'b011, 2'b00, 60'h77, 1'b1);
        applyStimulus(1, 3'b010, 2'b00, 60'h88, 1'b0);
        run_model();
        wait_pop(seen);
        checkOutput("withdraw_winner", seen, 4'b0001);
        src_q[1].delete();
        wait_drain(50);
        repeat (4) @(negedge clk);
        checkOutput("withdraw_stays_idle", busy, 0);

        // Randomised traffic with random back-pressure
        lat_en  = 1'b0;
        bp_rand = 1'b1;
        for (int b = 0; b < 5; b++) begin
            n = $urandom_range(6, 12);
            for (int j = 0; j < n; j++) begin
                applyStimulus($urandom_range(0, 3), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                              60'({$urandom(), $urandom()}), 1'b1);
            end
            run_model();
            wait_drain(3000);
        end
        bp_rand = 1'b0;

        // Asynchronous reset while stuck in DELIVER, then rotation restarts at device 0
        full_force = 4'b0100;
        applyStimulus(0, 3'b010, 2'b00, 60'hFFF, 1'b1);
        run_model();
        wait_pop(seen);
        @(negedge clk);
        checkOutput("pre_reset_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_pop", pop, 0);
        checkOutput("arst_push", push, 0);
        checkOutput("arst_d_push", D_push, 0);
        checkOutput("arst_grant", grant_id, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_err", err_dest, 0);
        exp_q.delete();
        for (int d = 0; d < DRVRS; d++) begin
            src_q[d].delete();
            mq[d].delete();
        end
        model_last = DRVRS - 1;
        full_force = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, 3'b000, 2'b01, 60'h1, 1'b1);
        applyStimulus(3, 3'b010, 2'b01, 60'h3, 1'b1);
        run_model();
        wait_pop(seen);
        checkOutput("after_reset_first", seen, 4'b0010);
        wait_drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and reset.
REQ-002 Parameter DRVRS, 4: number of bus devices, one source FIFO and one destination FIFO each.
REQ-003 Parameter PCKG_SZ, 65: packet width; [64:62] destination id, [61:60] tag, [59:0] payload.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 pndng  in  DRVRS  per-device source FIFO non-empty; head word valid on D_pop (first-word-fall-through).
REQ-007 D_pop  in  DRVRS x PCKG_SZ  per-device source FIFO head packet.
REQ-008 full  in  DRVRS  per-device destination FIFO full.
REQ-009 pop  out  DRVRS  one-cycle pop strobe to the source FIFO.
REQ-010 push  out  DRVRS  one-cycle push strobe to the destination FIFO(s).
REQ-011 D_push  out  PCKG_SZ  packet shared by all destination FIFOs.
REQ-012 grant_id  out  2  currently or last granted source.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 err_dest  out  1  one-cycle pulse when a packet is dropped for an invalid destination.

Function
REQ-015 FSM states SHALL be IDLE, POP, DELIVER and DROP.
REQ-016 IDLE: if any pndng is high, select the winner by round-robin, starting one above last_grant and wrapping at DRVRS-1; register grant_id; go to POP.
REQ-017 POP: pop[grant_id]=1 for exactly one cycle; capture D_pop[grant_id] into the packet register; update last_grant.
REQ-017a POP: destination id below DRVRS or equal to 3'b111 -> DELIVER; otherwise -> DROP.
REQ-018 DELIVER, unicast: wait until full[dest]=0, then push[dest]=1 for one cycle; go to IDLE.
REQ-018a A destination equal to the source SHALL be delivered as a loopback.
REQ-019 DELIVER, broadcast (id 3'b111): wait until full=0 on every device except the source, then assert push on all those devices in the same cycle; the source is never pushed.
REQ-020 D_push SHALL equal the packet register from POP until the push cycle, and hold stable while the block waits on full.
REQ-021 DROP: err_dest=1 for one cycle, no push; go to IDLE.
REQ-022 Latency: pndng seen at edge k -> pop at cycle k+1 -> earliest push at cycle k+2; 3 cycles per packet with no back-pressure.
REQ-023 The block SHALL hold at most one packet in flight; pndng changes outside IDLE are ignored.
REQ-024 A device whose pndng drops while it waits its turn SHALL lose the slot, with no side effect.
REQ-025 Except for broadcast, at most one pop bit and one push bit SHALL be high in any cycle.

Reset
REQ-026 While reset=0: state=IDLE, pop=0, push=0, D_push=0, grant_id=0, busy=0, err_dest=0, packet register=0, last_grant=DRVRS-1 (device 0 wins first).
REQ-027 Reset SHALL take effect asynchronously and mid-operation; an in-flight packet is discarded with no push.

Structure
REQ-028 Package bus_arb_pkg SHALL hold DRVRS, PCKG_SZ, the id field bounds, BROADCAST=3'b111 and the state enum.
REQ-029 Round-robin selection SHALL be a combinational sub-module, rr_picker (inputs: request vector and last grant; outputs: winner id and valid).

Verification
REQ-030 Single packet: pndng[0]=1 with D_pop[0]={3'b001,2'b00,60 ones} -> pop=4'b0001 next cycle; push=4'b0010 the cycle after; D_push equal to the packet; grant_id=0.
REQ-031 Fairness: pndng=4'b1111 held, all destinations valid -> grant order 0,1,2,3,0; one push every 3 cycles.
REQ-032 Broadcast from device 2 with id 3'b111 -> push=4'b1011 in a single cycle; push[2]=0.
REQ-033 Back-pressure: full[1]=1 for 5 cycles during DELIVER -> push=0 and D_push stable for 5 cycles; push[1] in the first cycle after full[1]=0.
REQ-034 Invalid destination 3'b101 -> pop asserted, then one err_dest pulse; push stays 0; block back in IDLE.
REQ-035 Reset during DELIVER -> all outputs 0 immediately without a clock edge; after release with pndng=4'b1010, device 1 is granted first.
